// File: rtl/z80_spislave_pkg.sv
// ============================================================================
// z80_spislave_pkg : shared state encoding and SPI mode-0 constants
// Rev 1.0
// ============================================================================
`default_nettype none

package z80_spislave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam logic       SPI_CPOL          = 1'b0;
    localparam logic       SPI_CPHA          = 1'b0;
    localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/z80_sync.sv
// ============================================================================
// z80_sync : single-bit multi-flop synchronizer, async active-low reset
// Rev 1.0
// ============================================================================
`default_nettype none

module z80_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/z80_spislave.sv
// ============================================================================
// z80_spislave : SPI mode-0 slave, oversampled on i_clk, with tx holding and
//                rx registers exposed through valid/ready handshakes
// Rev 1.0
// ============================================================================
`default_nettype none

module z80_spislave
    import z80_spislave_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = DEFAULT_IDLE_BYTE
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_sck,
    input  logic       i_ss_n,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_miso_en,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ack,
    output logic       o_busy,
    output logic       o_overrun,
    output logic       o_underrun,
    input  logic       i_clr_status
);

    logic sck_s, ss_s, mosi_s;
    logic sck_d, ss_d;
    logic sck_rise, sck_fall, ss_fall, ss_rise;

    z80_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_d(i_sck), .o_q(sck_s)
    );
    z80_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_d(i_ss_n), .o_q(ss_s)
    );
    z80_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_d(i_mosi), .o_q(mosi_s)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sck_d <= 1'b0;
            ss_d  <= 1'b1;
        end else begin
            sck_d <= sck_s;
            ss_d  <= ss_s;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign ss_fall  = ~ss_s & ss_d;
    assign ss_rise  = ss_s & ~ss_d;

    state_t state, state_next;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (ss_fall) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: state_next = ST_SHIFT;
            default:  state_next = ST_IDLE;
        endcase
        if (ss_rise) state_next = ST_IDLE;
    end

    logic [7:0] hold_data;
    logic       hold_full;
    logic [6:0] tx_shift;
    logic [7:0] rx_shift;
    logic [2:0] bit_cnt;
    logic       rx_done;
    logic       load_now, shift_out, sample, tx_write, rx_drop;
    logic [7:0] load_byte;

    // A fall with the counter wrapped to zero closes a byte: reload in place.
    assign load_now  = ~ss_rise & ((state == ST_LOAD) |
                       ((state == ST_SHIFT) & sck_fall & (bit_cnt == 3'd0)));
    assign shift_out = ~ss_rise & (state == ST_SHIFT) & sck_fall & (bit_cnt != 3'd0);
    assign sample    = ~ss_rise & (state == ST_SHIFT) & sck_rise;
    assign tx_write  = i_tx_valid & ~hold_full;
    assign load_byte = hold_full ? hold_data : IDLE_BYTE;
    assign rx_drop   = rx_done & o_rx_valid & ~i_rx_ack;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold_data <= 8'h00;
            hold_full <= 1'b0;
        end else begin
            if (tx_write) hold_data <= i_tx_data;
            hold_full <= (hold_full & ~load_now) | tx_write;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tx_shift  <= 7'h00;
            o_miso    <= 1'b1;
            o_miso_en <= 1'b0;
            bit_cnt   <= 3'd0;
            rx_shift  <= 8'h00;
            rx_done   <= 1'b0;
        end else begin
            if (load_now) begin
                tx_shift <= load_byte[6:0];
                o_miso   <= load_byte[7];
            end else if (shift_out) begin
                tx_shift <= {tx_shift[5:0], 1'b0};
                o_miso   <= tx_shift[6];
            end

            if (ss_rise)       o_miso_en <= 1'b0;
            else if (load_now) o_miso_en <= 1'b1;

            if (ss_rise || load_now) bit_cnt <= 3'd0;
            else if (sample)         bit_cnt <= bit_cnt + 3'd1;

            if (sample) rx_shift <= {rx_shift[6:0], mosi_s};
            rx_done <= sample & (bit_cnt == 3'd7);
        end
    end

    // Commit is one cycle after the 8th sample so rx_shift is settled.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rx_data  <= 8'h00;
            o_rx_valid <= 1'b0;
        end else if (rx_done && !rx_drop) begin
            o_rx_data  <= rx_shift;
            o_rx_valid <= 1'b1;
        end else if (i_rx_ack) begin
            o_rx_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_overrun  <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_overrun  <= rx_drop | (o_overrun & ~i_clr_status);
            o_underrun <= (load_now & ~hold_full) | (o_underrun & ~i_clr_status);
        end
    end

    assign o_tx_ready = ~hold_full;
    assign o_busy     = (state == ST_SHIFT) & (bit_cnt != 3'd0);

endmodule

`default_nettype wire
